// File: rtl/logic_sweep_pkg.sv
// Shared constants for the two-input logic cell sweep controller.
// State encoding, step count and truth-table width.
package logic_sweep_pkg;

  localparam int NUM_STEPS = 4;
  localparam int TBL_W     = 4;

  localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold timer: up-counter flagging the last cycle of each input hold.
// Wraps to zero on its own so consecutive steps need no reload.
module sweep_hold_timer #(
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == LAST_VAL);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Sweeps all four input combinations of a two-input logic cell, records
// its output per combination and compares the result against an expected table.
//
// state | meaning
// IDLE  | waiting for start, cell inputs parked at 00
// DRIVE | holding combination `step` on in1/in2, sampling out1 at end of hold
// DONE  | results final, done pulsed on entry, waits for next start
module logic_sweep_ctrl
  import logic_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 100,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [TBL_W-1:0] expected,
  output logic             in1,
  output logic             in2,
  input  logic             out1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [TBL_W-1:0] meas_table,
  output logic [TBL_W-1:0] fail_mask
);

  state_t           state;
  logic [1:0]       step;
  logic [1:0]       step_nxt;
  logic [TBL_W-1:0] exp_q;
  logic             start_ok;
  logic             timer_en;
  logic             hold_last;

  // start is only honoured outside DRIVE; abort freezes the timer so it never samples.
  assign start_ok = start && (state != DRIVE);
  assign timer_en = (state == DRIVE) && !abort;
  assign step_nxt = step + 2'd1;

  sweep_hold_timer #(
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .en    (timer_en),
    .last  (hold_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= '0;
      in1        <= 1'b0;
      in2        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      meas_table <= '0;
      exp_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            step       <= '0;
            exp_q      <= expected;
            meas_table <= '0;
            in1        <= 1'b0;
            in2        <= 1'b0;
            busy       <= 1'b1;
          end
        end
        DRIVE: begin
          if (abort) begin
            state <= IDLE;
            in1   <= 1'b0;
            in2   <= 1'b0;
            busy  <= 1'b0;
          end else if (hold_last) begin
            meas_table[step] <= out1;
            if (step == LAST_STEP) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              in1   <= 1'b0;
              in2   <= 1'b0;
            end else begin
              step <= step_nxt;
              in1  <= step_nxt[0];
              in2  <= step_nxt[1];
            end
          end
        end
        default: begin
          state <= IDLE;
          in1   <= 1'b0;
          in2   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign fail_mask = meas_table ^ exp_q;
  assign pass      = (state == DONE) && (fail_mask == '0);

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl with HOLD_CYCLES=4 driving a LUT-based cell model.
// Expected behaviour is derived from the sweep timeline and the cell's truth table.
module tb_logic_sweep_ctrl;

  localparam int H     = 4;
  localparam int SWEEP = 4 * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] expected;
  logic [3:0] cell_lut;
  logic       in1, in2, out1;
  logic       busy, done, pass;
  logic [3:0] meas_table, fail_mask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Cell under test: arbitrary two-input function given by its truth table.
  assign out1 = cell_lut[{in2, in1}];

  logic_sweep_ctrl #(
    .HOLD_CYCLES (H),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .expected   (expected),
    .in1        (in1),
    .in2        (in2),
    .out1       (out1),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .meas_table (meas_table),
    .fail_mask  (fail_mask)
  );

  // Call at a negedge; start is high for the current cycle (cycle 0).
  // Returns at the negedge of the done cycle with start low.
  task automatic sweep_check(input logic [3:0] lut, input logic [3:0] exp_v,
                             input int ign_cyc, input bit with_abort, input string name);
    logic [1:0] s;
    logic       w_busy, w_done, w_i1, w_i2;
    cell_lut = lut;
    expected = exp_v;
    start    = 1'b1;
    abort    = with_abort;
    for (int n = 1; n <= SWEEP + 1; n++) begin
      @(negedge clk);
      start = (n == ign_cyc);
      abort = 1'b0;
      if (n == 1) expected = 4'($urandom);
      w_busy = (n <= SWEEP);
      w_done = (n == SWEEP + 1);
      s      = 2'((n - 1) / H);
      w_i1   = (n <= SWEEP) ? s[0] : 1'b0;
      w_i2   = (n <= SWEEP) ? s[1] : 1'b0;
      checks++;
      if ({busy, done, in1, in2} !== {w_busy, w_done, w_i1, w_i2}) begin
        failures++;
        $display("FAIL %s cyc=%0d busy,done,in1,in2 got=%b want=%b", name, n,
                 {busy, done, in1, in2}, {w_busy, w_done, w_i1, w_i2});
      end
      if (n == 1) begin
        checks++;
        if ({meas_table, pass} !== 5'b0) begin
          failures++;
          $display("FAIL %s cleared_on_start table,pass got=%b want=00000", name, {meas_table, pass});
        end
      end
      if (n == SWEEP + 1) begin
        checks++;
        if (meas_table !== lut) begin
          failures++;
          $display("FAIL %s table got=%b want=%b", name, meas_table, lut);
        end
        checks++;
        if (fail_mask !== (lut ^ exp_v)) begin
          failures++;
          $display("FAIL %s fail_mask got=%b want=%b", name, fail_mask, lut ^ exp_v);
        end
        checks++;
        if (pass !== (lut == exp_v)) begin
          failures++;
          $display("FAIL %s pass got=%b want=%b", name, pass, (lut == exp_v));
        end
      end
    end
  endtask

  // Stays in DONE: no further done, results stable, abort ignored.
  task automatic test_done_hold(input logic [3:0] lut, input logic [3:0] exp_v, input string name);
    for (int n = 0; n < 5; n++) begin
      abort = (n < 2);
      @(negedge clk);
      checks++;
      if ({busy, done, in1, in2, pass, meas_table} !== {4'b0000, (lut == exp_v), lut}) begin
        failures++;
        $display("FAIL %s done_hold cyc=%0d busy,done,in1,in2,pass,table got=%b want=%b", name, n,
                 {busy, done, in1, in2, pass, meas_table}, {4'b0000, (lut == exp_v), lut});
      end
    end
    abort = 1'b0;
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({in1, in2, busy, done, pass, meas_table, fail_mask} !== 13'b0) begin
      failures++;
      $display("FAIL %s reset outputs got=%b want=0", name,
               {in1, in2, busy, done, pass, meas_table, fail_mask});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; expected = 4'hF; cell_lut = 4'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_and();
    sweep_check(4'b1000, 4'b1000, 0, 1'b0, "and");
    test_done_hold(4'b1000, 4'b1000, "and");
  endtask

  task automatic test_xor_restart();
    sweep_check(4'b0110, 4'b0110, 0, 1'b0, "xor1");
    sweep_check(4'b0110, 4'b0110, 0, 1'b0, "xor2");
    test_done_hold(4'b0110, 4'b0110, "xor2");
  endtask

  task automatic test_or_wrong();
    sweep_check(4'b1110, 4'b1000, 0, 1'b0, "or_wrong");
    test_done_hold(4'b1110, 4'b1000, "or_wrong");
  endtask

  task automatic test_start_in_drive();
    sweep_check(4'b1000, 4'b1000, 6, 1'b0, "start_in_drive");
    test_done_hold(4'b1000, 4'b1000, "start_in_drive");
  endtask

  task automatic test_rst_mid();
    bit seen_done;
    cell_lut = 4'b1111; expected = 4'b1111; start = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 9) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("rst_mid");
    seen_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL rst_mid activity after reset got=1 want=0");
    end
    sweep_check(4'b0111, 4'b0111, 0, 1'b0, "after_rst");
  endtask

  task automatic test_abort(input int abort_cyc);
    logic [3:0] lut;
    bit         activity;
    lut = 4'($urandom) | 4'b0100;
    cell_lut = lut; expected = lut; start = 1'b1;
    for (int n = 1; n <= abort_cyc; n++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (n == abort_cyc);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, in1, in2, pass} !== 5'b0) begin
      failures++;
      $display("FAIL abort@%0d busy,done,in1,in2,pass got=%b want=00000", abort_cyc,
               {busy, done, in1, in2, pass});
    end
    checks++;
    if (meas_table !== {2'b00, lut[1:0]}) begin
      failures++;
      $display("FAIL abort@%0d partial table got=%b want=%b", abort_cyc, meas_table, {2'b00, lut[1:0]});
    end
    activity = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b0) activity = 1'b1;
    end
    checks++;
    if (activity) begin
      failures++;
      $display("FAIL abort@%0d idle_after_abort got=active want=idle", abort_cyc);
    end
  endtask

  task automatic test_start_with_abort();
    sweep_check(4'b0001, 4'b0001, 0, 1'b1, "start_with_abort");
  endtask

  task automatic test_random();
    logic [3:0] lut, exp_v;
    for (int i = 0; i < 6; i++) begin
      lut   = 4'($urandom);
      exp_v = ($urandom_range(0, 1) == 1) ? lut : 4'($urandom);
      sweep_check(lut, exp_v, 0, 1'b0, "random");
      test_done_hold(lut, exp_v, "random");
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_restart();
    test_or_wrong();
    test_start_in_drive();
    test_rst_mid();
    test_abort(10);
    test_abort(12);
    test_start_with_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
